serial_tx_arb: RTL and testbench

SERIAL_TX_ARB -- requirements
Module: serial_tx_arb

---
 rtl/serial_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/serial_tx_arb.sv | 105 ++++++++++
 tb/tb_serial_tx_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial_tx arbiter: FSM encoding, id width and frame header layout.
package serial_pkg;

  localparam int unsigned ID_W        = 3;
  localparam int unsigned HDR_MAGIC_W = 16;
  localparam int unsigned HDR_ID_W    = 8;
  localparam int unsigned HDR_CNT_W   = 8;

  localparam logic [HDR_MAGIC_W-1:0] HDR_MAGIC = 16'h55AA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [HDR_MAGIC_W-1:0] magic;
    logic [HDR_ID_W-1:0]    id;
    logic [HDR_CNT_W-1:0]   cnt;
  } hdr_t;

  // Header word placed in front of every payload.
  function automatic hdr_t make_hdr(input logic [ID_W-1:0] id, input logic [HDR_CNT_W-1:0] cnt);
    hdr_t h;
    h.magic = HDR_MAGIC;
    h.id    = HDR_ID_W'(id);
    h.cnt   = cnt;
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: first asserted request at or after the pointer, wrapping.
module rr_arbiter
  import serial_pkg::*;
#(
  parameter int unsigned REQ_NUM = 4
) (
  input  logic [REQ_NUM-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [REQ_NUM-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  localparam int unsigned IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  always_comb begin : p_search
    int unsigned k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      k = (32'(i_ptr) + i) % REQ_NUM;
      if (!o_any && i_req[IW'(k)]) begin
        o_any            = 1'b1;
        o_grant[IW'(k)]  = 1'b1;
        o_idx            = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arb.sv
// Arbitrates REQ_NUM word requesters onto one serializer port, framing each word as
// header + payload followed by IDLE_GAP idle cycles.
module serial_tx_arb
  import serial_pkg::*;
#(
  parameter real         TCQ        = 0.1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned IDLE_GAP   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REQ_NUM-1:0]            req_valid_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
  output logic [REQ_NUM-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned GAP_W = 4;

  if (DATA_WIDTH != 32 || REQ_NUM < 2 || REQ_NUM > 8 || IDLE_GAP > 15 || TCQ < 0.0) begin : g_bad_param
    $error("serial_tx_arb: illegal parameter set");
  end

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, r_grant_id, w_idx;
  logic [HDR_CNT_W-1:0]  r_frame_cnt;
  logic [DATA_WIDTH-1:0] r_payload, r_tx_data, w_sel_data;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [REQ_NUM-1:0]    w_grant;
  logic                  r_tx_valid, r_busy;
  logic                  w_any, w_accept, w_gap_last;

  rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Accept strobe is combinational so the winner is taken in the grant cycle itself.
  assign w_accept    = (r_state == ST_IDLE) && w_any && !rst_i;
  assign req_ready_o = w_accept ? w_grant : '0;
  assign w_gap_last  = (r_gap_cnt == GAP_W'(IDLE_GAP - 1));

  assign tx_valid_o = r_tx_valid;
  assign tx_data_o  = r_tx_data;
  assign grant_id_o = r_grant_id;
  assign busy_o     = r_busy;

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (w_grant[k]) w_sel_data = w_sel_data | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any)      w_state_nxt = ST_HEAD;
      ST_HEAD: if (tx_ready_i) w_state_nxt = ST_DATA;
      ST_DATA: if (tx_ready_i) w_state_nxt = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (w_gap_last) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are registered from the next state so they line up with the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_frame_cnt <= '0;
      r_payload   <= '0;
      r_tx_data   <= '0;
      r_gap_cnt   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_valid <= (w_state_nxt == ST_HEAD) || (w_state_nxt == ST_DATA);
      r_busy     <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_payload  <= w_sel_data;
        r_grant_id <= w_idx;
        r_rr_ptr   <= ID_W'((32'(w_idx) + 32'd1) % REQ_NUM);
        r_tx_data  <= DATA_WIDTH'(make_hdr(w_idx, r_frame_cnt));
      end
      if (r_state == ST_HEAD && tx_ready_i) r_tx_data <= r_payload;
      if (r_state == ST_DATA && tx_ready_i) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (r_state == ST_GAP) r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_tx_arb.sv
// Bench for serial_tx_arb: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, and a second instance with IDLE_GAP=0.
module tb_serial_tx_arb;

  localparam int N   = 4;
  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_data;
  logic            tx_valid, tx_ready, busy;
  logic [31:0]     tx_data;
  logic [2:0]      grant_id;

  logic            rst0;
  logic [N-1:0]    req_valid0, req_ready0;
  logic [N*32-1:0] req_data0;
  logic            tx_valid0, tx_ready0, busy0;
  logic [31:0]     tx_data0;
  logic [2:0]      grant_id0;

  serial_tx_arb #(.REQ_NUM(N), .IDLE_GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_id_o(grant_id), .busy_o(busy)
  );

  serial_tx_arb #(.REQ_NUM(N), .IDLE_GAP(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .req_valid_i(req_valid0), .req_data_i(req_data0),
    .req_ready_o(req_ready0), .tx_valid_o(tx_valid0), .tx_data_o(tx_data0),
    .tx_ready_i(tx_ready0), .grant_id_o(grant_id0), .busy_o(busy0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: words still owed to the serializer, gap cycles left, pointer, counter.
  logic [31:0] m_words[$];
  int          m_gap, m_ptr, m_id, win;
  logic [7:0]  m_cnt;
  logic [N-1:0] exp_ready, acc_mask;

  // Observed traffic for the directed scenarios.
  logic [31:0] got[$];
  int          got_t[$];
  int          gl[$];
  logic [31:0] got0[$];
  int          got0_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_id", grant_id, 0);
      m_words.delete();
      m_gap = 0; m_ptr = 0; m_id = 0; m_cnt = 8'd0;
      acc_mask = '0;
    end else begin
      win = -1;
      exp_ready = '0;
      if (m_words.size() == 0 && m_gap == 0) begin
        for (int i = 0; i < N; i++)
          if (win < 0 && req_valid[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        if (win >= 0) exp_ready[win] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("tx_valid", tx_valid, m_words.size() > 0);
      if (m_words.size() > 0) chk("tx_data", tx_data, m_words[0]);
      chk("busy", busy, (m_words.size() > 0) || (m_gap > 0));
      chk("grant_id", grant_id, 3'(m_id));
      acc_mask = req_valid & req_ready;
      for (int k = 0; k < N; k++) if (acc_mask[k]) gl.push_back(k);
      if (tx_valid && tx_ready) begin got.push_back(tx_data); got_t.push_back(cyc); end
      // advance to the state seen after the coming rising edge
      if (m_words.size() > 0) begin
        if (tx_ready) begin
          void'(m_words.pop_front());
          if (m_words.size() == 0) begin m_cnt = m_cnt + 8'd1; m_gap = GAP; end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (win >= 0) begin
        m_words.push_back({16'h55AA, 8'(win), m_cnt});
        m_words.push_back(req_data[win*32 +: 32]);
        m_ptr = (win + 1) % N;
        m_id  = win;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst0 && tx_valid0 && tx_ready0) begin got0.push_back(tx_data0); got0_t.push_back(cyc); end
  end

  function automatic logic [31:0] w_at(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int t_at(input int i);
    return (i < got_t.size()) ? got_t[i] : -1000;
  endfunction
  function automatic logic [31:0] w0_at(input int i);
    return (i < got0.size()) ? got0[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int t0_at(input int i);
    return (i < got0_t.size()) ? got0_t[i] : -1000;
  endfunction

  task automatic clear_logs();
    got.delete(); got_t.delete(); gl.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  // keep: requesters that re-raise valid with a fresh word right after each accept.
  task automatic run_keep(input int n, input logic [N-1:0] keep, input logic rdy);
    repeat (n) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc_mask[k]) begin
          req_valid[k] = 1'b0;
          if (keep[k]) req_data[k*32 +: 32] = req_data[k*32 +: 32] + 32'd1;
        end
        if (keep[k]) req_valid[k] = 1'b1;
      end
      tx_ready = rdy;
    end
  endtask

  task automatic rand_cycles(input int n, input int p_req, input int p_rdy);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~acc_mask;
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k]) begin
          if ($urandom_range(99) < p_req) begin
            req_valid[k] = 1'b1;
            req_data[k*32 +: 32] = $urandom();
          end
        end else if (m_words.size() > 0 || m_gap > 0) begin
          req_data[k*32 +: 32] = $urandom();
        end
      end
      tx_ready = ($urandom_range(99) < p_rdy);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_data = '0; tx_ready = 1'b1;
    rst0 = 1'b1; req_valid0 = '0; req_data0 = '0; tx_ready0 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_ready_gated", req_ready, 0);
    chk("init_busy", busy, 0);
    chk("init_dut0_busy", busy0, 0);
    chk("init_dut0_ready", req_ready0, 0);
    do_reset();

    // Single request from req0, serializer always ready.
    req_data[31:0] = 32'hDEAD_BEEF;
    run_keep(25, 4'b0001, 1'b1);
    chk("single_hdr", w_at(0), 32'h55AA_0000);
    chk("single_data", w_at(1), 32'hDEAD_BEEF);
    chk("single_hdr2", w_at(2), 32'h55AA_0001);
    chk("single_data2", w_at(3), 32'hDEAD_BEF0);
    chk("single_gap", t_at(2) - t_at(1), 6);

    // All four requesters continuously valid.
    do_reset();
    for (int k = 0; k < N; k++) req_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    run_keep(40, 4'b1111, 1'b1);
    chk("rr_g0", (gl.size() > 0) ? gl[0] : -1, 0);
    chk("rr_g1", (gl.size() > 1) ? gl[1] : -1, 1);
    chk("rr_g2", (gl.size() > 2) ? gl[2] : -1, 2);
    chk("rr_g3", (gl.size() > 3) ? gl[3] : -1, 3);
    chk("rr_g4", (gl.size() > 4) ? gl[4] : -1, 0);
    chk("rr_h0", w_at(0), 32'h55AA_0000);
    chk("rr_d0", w_at(1), 32'hA000_0000);
    chk("rr_h1", w_at(2), 32'h55AA_0101);
    chk("rr_h2", w_at(4), 32'h55AA_0202);
    chk("rr_h3", w_at(6), 32'h55AA_0303);
    chk("rr_d3", w_at(7), 32'hA000_0003);
    chk("rr_h4", w_at(8), 32'h55AA_0004);

    // Serializer back-pressure in HEAD and in DATA.
    do_reset();
    req_data[63:32] = 32'h1234_5678;
    req_valid = 4'b0010;
    run_keep(7, 4'b0000, 1'b0);
    run_keep(1, 4'b0000, 1'b1);
    run_keep(5, 4'b0000, 1'b0);
    run_keep(12, 4'b0000, 1'b1);
    chk("stall_count", got.size(), 2);
    chk("stall_hdr", w_at(0), 32'h55AA_0100);
    chk("stall_data", w_at(1), 32'h1234_5678);

    // 257 frames from req2: header counter wraps.
    do_reset();
    req_data[95:64] = 32'h0;
    run_keep(1820, 4'b0100, 1'b1);
    chk("wrap_count", got.size() >= 514, 1);
    for (int i = 0; i < 257; i++) chk("wrap_hdr", w_at(2*i), {16'h55AA, 8'd2, 8'(i)});

    // Reset in the middle of a DATA stall.
    do_reset();
    req_data[63:32] = 32'hCAFE_F00D;
    req_valid = 4'b0010;
    run_keep(1, 4'b0000, 1'b0);
    run_keep(1, 4'b0000, 1'b1);
    run_keep(3, 4'b0000, 1'b0);
    @(posedge clk); #1;
    chk("abort_pre_data", tx_data, 32'hCAFE_F00D);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_data", tx_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_id", grant_id, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    req_data[31:0] = 32'h0000_1111; req_data[95:64] = 32'h2222_0000;
    req_valid = 4'b0101; tx_ready = 1'b1;
    run_keep(25, 4'b0000, 1'b1);
    chk("abort_count", got.size(), 4);
    chk("abort_h0", w_at(0), 32'h55AA_0000);
    chk("abort_d0", w_at(1), 32'h0000_1111);
    chk("abort_h1", w_at(2), 32'h55AA_0201);
    chk("abort_d1", w_at(3), 32'h2222_0000);

    // IDLE_GAP=0 instance with req1 held valid.
    @(posedge clk); #1;
    rst0 = 1'b0; req_valid0 = 4'b0010; req_data0[63:32] = 32'h0BAD_F00D; tx_ready0 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("g0_h0", w0_at(0), 32'h55AA_0100);
    chk("g0_d0", w0_at(1), 32'h0BAD_F00D);
    chk("g0_h1", w0_at(2), 32'h55AA_0101);
    chk("g0_h2", w0_at(4), 32'h55AA_0102);
    chk("g0_gap1", t0_at(2) - t0_at(1), 2);
    chk("g0_gap2", t0_at(4) - t0_at(3), 2);
    chk("g0_id", grant_id0, 1);

    // Randomized traffic against the model, with a reset in between.
    do_reset();
    rand_cycles(1500, 30, 60);
    do_reset();
    rand_cycles(1500, 50, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
